// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: forms base+offset, checks alignment and range,
// and performs byte/half/word loads and stores against an internal word RAM.
module load_store_unit #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [31:0] ea,
    output logic        addr_err
);

    // state  | meaning
    // IDLE   | waiting for start
    // CALC   | form effective address, check alignment/range
    // RD     | RAM read issued at ea word
    // EXT    | load: extract/extend lane; sub-word store: merge lane
    // WR     | RAM write of full or merged word
    // DONE   | one-cycle completion pulse
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_EXT  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [2:0]    state;
    logic          op_store;
    logic          op_unsigned;
    logic [1:0]    op_size;
    logic [31:0]   op_base;
    logic [31:0]   op_offset;
    logic [31:0]   op_wdata;
    logic [31:0]   ea_sum;
    logic          calc_err;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [31:0]   merged;
    logic [31:0]   ext_val;
    logic [31:0]   wr_data;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [AW-1:0] waddr;

    logic [31:0] mem [DEPTH_WORDS];

    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);
    assign ea_sum  = op_base + op_offset;
    assign waddr   = ea[AW+1:2];
    assign wr_data = (op_size == 2'b10) ? op_wdata : wr_word;

    always_comb begin
        calc_err = 1'b0;
        case (op_size)
            2'b00:   calc_err = 1'b0;
            2'b01:   calc_err = ea_sum[0];
            2'b10:   calc_err = |ea_sum[1:0];
            default: calc_err = 1'b1;
        endcase
        if ({2'b00, ea_sum[31:2]} >= 32'(DEPTH_WORDS))
            calc_err = 1'b1;
    end

    // Little-endian lanes: byte lane is ea[1:0], half lane is ea[1].
    always_comb begin
        lane_b  = rd_word[{ea[1:0], 3'b000} +: 8];
        lane_h  = ea[1] ? rd_word[31:16] : rd_word[15:0];
        ext_val = rd_word;
        merged  = rd_word;
        case (op_size)
            2'b00: begin
                ext_val = op_unsigned ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merged[{ea[1:0], 3'b000} +: 8] = op_wdata[7:0];
            end
            2'b01: begin
                ext_val = op_unsigned ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                if (ea[1])
                    merged[31:16] = op_wdata[15:0];
                else
                    merged[15:0] = op_wdata[15:0];
            end
            default: begin
                ext_val = rd_word;
                merged  = op_wdata;
            end
        endcase
    end

    // RAM is not reset; a reset asserted before the WR edge leaves state IDLE,
    // so the write is suppressed.
    always_ff @(posedge clk) begin
        if (state == S_RD)
            rd_word <= mem[waddr];
        if (state == S_WR)
            mem[waddr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_store    <= 1'b0;
            op_unsigned <= 1'b0;
            op_size     <= 2'b00;
            op_base     <= 32'h0;
            op_offset   <= 32'h0;
            op_wdata    <= 32'h0;
            wr_word     <= 32'h0;
            rdata       <= 32'h0;
            ea          <= 32'h0;
            addr_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_store    <= is_store;
                        op_size     <= size;
                        op_unsigned <= unsigned_ld;
                        op_base     <= base;
                        op_offset   <= offset;
                        op_wdata    <= wdata;
                        addr_err    <= 1'b0;
                        state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    ea <= ea_sum;
                    if (calc_err) begin
                        addr_err <= 1'b1;
                        state    <= S_DONE;
                    end else if (!op_store) begin
                        state <= S_RD;
                    end else if (op_size == 2'b10) begin
                        state <= S_WR;
                    end else begin
                        state <= S_RD;
                    end
                end
                S_RD: state <= S_EXT;
                S_EXT: begin
                    if (op_store) begin
                        wr_word <= merged;
                        state   <= S_WR;
                    end else begin
                        rdata <= ext_val;
                        state <= S_DONE;
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency, lane extract/merge, errors,
// handshake and reset-during-write behaviour.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [31:0] ea;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    load_store_unit #(.DEPTH_WORDS(256)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .size(size),
        .unsigned_ld(unsigned_ld), .base(base), .offset(offset), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .ea(ea), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one request at the negedge before cycle 0; returns the cycle done was seen.
    task automatic do_op(input logic st, input logic [1:0] sz, input logic us,
                         input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                         output int cyc);
        @(negedge clk);
        start = 1'b1; is_store = st; size = sz; unsigned_ld = us;
        base = b; offset = o; wdata = w;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
        end
        if (cyc < 0) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input string tag, input logic st, input logic [1:0] sz, input logic us,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] w,
                       input int exp_cyc, input logic exp_err);
        int cyc;
        do_op(st, sz, us, b, o, w, cyc);
        chk({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, "_err"}, {31'h0, addr_err}, {31'h0, exp_err});
    endtask

    initial begin
        int cyc;
        int ndone;
        int dcyc [3];
        logic [31:0] prev;

        rst = 1'b1; start = 1'b0; is_store = 1'b0; size = SZ_W; unsigned_ld = 1'b0;
        base = '0; offset = '0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ea", ea, 32'h0);
        chk("rst_err", {31'h0, addr_err}, 32'h0);
        rst = 1'b0;

        // word store / load round trip
        run("st_w", 1, SZ_W, 0, 32'h10, 32'h4, 32'hDEADBEEF, 3, 0);
        chk("st_w_ea", ea, 32'h14);
        run("ld_w", 0, SZ_W, 0, 32'h10, 32'h4, 32'h0, 4, 0);
        chk("ld_w_data", rdata, 32'hDEADBEEF);

        // byte read-modify-write and extension
        run("st_b", 1, SZ_B, 0, 32'h15, 32'h0, 32'h12345680, 5, 0);
        run("ld_w2", 0, SZ_W, 0, 32'h14, 32'h0, 32'h0, 4, 0);
        chk("ld_w2_data", rdata, 32'hDEAD80EF);
        run("ld_bs", 0, SZ_B, 0, 32'h15, 32'h0, 32'h0, 4, 0);
        chk("ld_bs_data", rdata, 32'hFFFFFF80);
        run("ld_bu", 0, SZ_B, 1, 32'h15, 32'h0, 32'h0, 4, 0);
        chk("ld_bu_data", rdata, 32'h00000080);
        run("ld_hs", 0, SZ_H, 0, 32'h16, 32'h0, 32'h0, 4, 0);
        chk("ld_hs_data", rdata, 32'hFFFFDEAD);
        run("ld_hu", 0, SZ_H, 1, 32'h16, 32'h0, 32'h0, 4, 0);
        chk("ld_hu_data", rdata, 32'h0000DEAD);

        // halfword RMW in the low lane
        run("st_h", 1, SZ_H, 0, 32'h14, 32'h0, 32'hAAAA1234, 5, 0);
        run("ld_w3", 0, SZ_W, 0, 32'h14, 32'h0, 32'h0, 4, 0);
        chk("ld_w3_data", rdata, 32'hDEAD1234);
        run("ld_b3", 0, SZ_B, 0, 32'h17, 32'h0, 32'h0, 4, 0);
        chk("ld_b3_data", rdata, 32'hFFFFFFDE);

        // negative offset
        run("st_neg", 1, SZ_W, 0, 32'h100, 32'hFFFFFFFC, 32'hCAFEF00D, 3, 0);
        chk("st_neg_ea", ea, 32'hFC);
        run("ld_neg", 0, SZ_W, 0, 32'hF8, 32'h4, 32'h0, 4, 0);
        chk("ld_neg_data", rdata, 32'hCAFEF00D);
        run("neg_wrap", 0, SZ_W, 0, 32'h0, 32'hFFFFFFFC, 32'h0, 2, 1);
        chk("neg_wrap_ea", ea, 32'hFFFFFFFC);

        // range boundary
        run("top_ok", 1, SZ_W, 0, 32'h3FC, 32'h0, 32'h0BADF00D, 3, 0);
        run("top_ld", 0, SZ_W, 0, 32'h3FC, 32'h0, 32'h0, 4, 0);
        chk("top_ld_data", rdata, 32'h0BADF00D);
        run("over", 1, SZ_B, 0, 32'h400, 32'h0, 32'h0, 2, 1);

        // misaligned / illegal: memory and rdata unchanged
        run("ld_w4", 0, SZ_W, 0, 32'h14, 32'h0, 32'h0, 4, 0);
        prev = rdata;
        run("mis_w", 1, SZ_W, 0, 32'h16, 32'h0, 32'h55555555, 2, 1);
        chk("mis_w_ea", ea, 32'h16);
        run("mis_h", 1, SZ_H, 0, 32'h15, 32'h0, 32'h55555555, 2, 1);
        run("ill_sz", 1, SZ_X, 0, 32'h14, 32'h0, 32'h55555555, 2, 1);
        run("mis_hl", 0, SZ_H, 0, 32'h15, 32'h0, 32'h0, 2, 1);
        chk("err_rdata", rdata, prev);
        run("ld_w5", 0, SZ_W, 0, 32'h14, 32'h0, 32'h0, 4, 0);
        chk("ld_w5_data", rdata, 32'hDEAD1234);

        // start pulsed in cycles 1-4 of a load is ignored
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; size = SZ_W; unsigned_ld = 1'b0;
        base = 32'h14; offset = 32'h0;
        @(posedge clk);
        ndone = 0; cyc = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) chk("hs_busy1", {31'h0, busy}, 32'h1);
            if (done) begin ndone++; cyc = c; end
            start = (c <= 3);
            base = 32'hFC;
        end
        start = 1'b0;
        chk("hs_ndone", 32'(ndone), 32'd1);
        chk("hs_cyc", 32'(cyc), 32'd4);
        chk("hs_data", rdata, 32'hDEAD1234);

        // start held high: accepts at 0, then the cycle after each done
        @(negedge clk);
        start = 1'b1; base = 32'h14; offset = 32'h0; size = SZ_W; is_store = 1'b0;
        @(posedge clk);
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) dcyc[ndone] = c;
                ndone++;
            end
            if (c == 14) start = 1'b0;
        end
        chk("hold_ndone", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            chk("hold_d0", 32'(dcyc[0]), 32'd4);
            chk("hold_d1", 32'(dcyc[1]), 32'd9);
            chk("hold_d2", 32'(dcyc[2]), 32'd14);
        end

        // reset in cycle 2 of a word store suppresses the write
        run("pre_rst", 1, SZ_W, 0, 32'h20, 32'h0, 32'h11111111, 3, 0);
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; size = SZ_W; base = 32'h20; offset = 32'h0;
        wdata = 32'h22222222;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_busy", {31'h0, busy}, 32'h0);
        chk("mid_done", {31'h0, done}, 32'h0);
        chk("mid_rdata", rdata, 32'h0);
        chk("mid_ea", ea, 32'h0);
        chk("mid_err", {31'h0, addr_err}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_done2", {31'h0, done}, 32'h0);
        rst = 1'b0;
        run("post_rst", 0, SZ_W, 0, 32'h20, 32'h0, 32'h0, 4, 0);
        chk("post_rst_data", rdata, 32'h11111111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory load/store unit sitting directly downstream of the 16→32 sign extender. It adds the sign-extended immediate offset to a base register value to form the effective address, checks alignment and range, and performs byte/halfword/word loads (signed or unsigned) and stores against an internal word-wide synchronous RAM. Sub-word stores use read-modify-write. A start/busy/done handshake connects it to the control FSM.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- is_store  in  1  1=store, 0=load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  in  1  loads: 1=zero-extend, 0=sign-extend.
- base  in  32  base register value.
- offset  in  32  sign-extended immediate.
- wdata  in  32  store data; the low byte/half is used for sub-word stores.
- busy  out  1  high whenever state≠IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  registered load result; holds until the next successful load.
- ea  out  32  registered effective address of the current/last op.
- addr_err  out  1  error status of the last op; valid with done and held until the next accept.

## Operation
- Accept: when start=1 and the state is IDLE, latch is_store, size, unsigned_ld, base, offset and wdata, and clear addr_err. Inputs are ignored while busy, including during the DONE cycle.
- States: IDLE, CALC, RD, EXT, WR, DONE.
- CALC
  - ea ← base+offset, modulo 2^32; no overflow flag.
  - An error is raised if any of: size=11; halfword with ea[0]=1; word with ea[1:0]≠00; ea[31:2] ≥ DEPTH_WORDS.
  - On error, set addr_err=1 and go to DONE. On an error, memory and rdata are unchanged.
  - Otherwise: load → RD; word store → WR; sub-word store → RD.
- RD: issue a RAM read at word address ea[31:2]. Data is valid in EXT.
- EXT
  - Lanes are little-endian: byte lane = ea[1:0], half lane = ea[1].
  - Load: extract the lane, extend per unsigned_ld, register into rdata, go to DONE.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the read word at the lane, go to WR.
- WR: write the word (full wdata or the merged word) at ea[31:2], go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Reset values: state IDLE, busy 0, done 0, rdata 0, ea 0, addr_err 0. RAM contents are not reset and are undefined at power-up.
- Reset mid-operation: return to IDLE immediately.
  - No write occurs unless the WR-state clock edge preceded reset assertion.
  - Latched request data is discarded; done is not pulsed.

## Timing
- Cycle 0 is the cycle in which start is high and accepted. busy is high from cycle 1 through the DONE cycle inclusive.
- done cycle by operation:
  - load: cycle 4 (CALC 1, RD 2, EXT 3, DONE 4).
  - word store: cycle 3 (CALC, WR, DONE).
  - sub-word store: cycle 5 (CALC, RD, EXT, WR, DONE).
  - error: cycle 2 (CALC, DONE).
- ea is valid from cycle 2. rdata updates at the edge entering DONE and is valid while done=1.
- Earliest next accept is the cycle after done, giving back-to-back throughput of one op per latency+1 cycles.
- Write data is visible to a following load because RAM writes complete before DONE.

## Test plan
- Word store then load: store base=0x10, offset=0x4, wdata=0xDEADBEEF → done in cycle 3, ea=0x14. Load the same address → done in cycle 4, rdata=0xDEADBEEF, addr_err=0.
- Byte RMW and extension:
  - Store byte 0x80 to ea=0x15 → done in cycle 5.
  - Word load at 0x14 → 0xDEAD80EF.
  - Signed byte load at 0x15 → 0xFFFFFF80; unsigned → 0x00000080.
  - Signed half load at 0x16 → 0xFFFFDEAD.
- Negative offset: base=0x100, offset=0xFFFFFFFC → ea=0xFC, word store/load round-trips correctly. base=0, offset=0xFFFFFFFC → ea=0xFFFFFFFC, addr_err=1, done in cycle 2.
- Misaligned/illegal:
  - Word op at ea=0x16, half op at ea=0x15, size=11 → each gives addr_err=1, done in cycle 2.
  - A subsequent load shows memory unchanged and rdata unchanged.
- Handshake: pulse start again in cycles 1–4 of a load → ignored, exactly one done. start held high continuously → ops accepted in cycle 0, then the cycle after each done.
- Reset mid-op: assert rst in cycle 2 of a word store to a location holding 0x11111111 → busy=0 and done=0 immediately, a later load returns 0x11111111, and all outputs hold their reset values.
